// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared zone-grid defaults, brightness type and index helpers
package video_pkg;

    localparam int DEF_H_ACT     = 1920;
    localparam int DEF_V_ACT     = 1080;
    localparam int DEF_ZONE_COLS = 24;
    localparam int DEF_ZONE_ROWS = 15;
    localparam int NZ            = DEF_ZONE_COLS * DEF_ZONE_ROWS;
    localparam int BRIGHT_W      = 8;

    typedef logic [BRIGHT_W-1:0] bright_t;

    function automatic int zone_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

    function automatic bright_t max3(input bright_t a, input bright_t b, input bright_t c);
        bright_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/zone_counter.sv
// rtl/zone_counter.sv - in-zone unit counter that advances a zone index and saturates at ZONES
module zone_counter #(
    parameter int SPAN  = 80,
    parameter int ZONES = 24,
    localparam int ZW   = $clog2(ZONES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [ZW-1:0] zone,
    output logic          last,
    output logic          done
);

    localparam int CW = (SPAN > 1) ? $clog2(SPAN) : 1;

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(SPAN - 1));
    // zone == ZONES means the full span has been seen; further increments are held off
    assign done = (zone == ZW'(ZONES));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            zone <= '0;
        end else if (inc && !done) begin
            if (last) begin
                cnt  <= '0;
                zone <= zone + ZW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/video_zone_luma.sv
// rtl/video_zone_luma.sv - per-frame zone brightness (max of max(R,G,B)) for MiniLED backlight
module video_zone_luma
    import video_pkg::*;
#(
    parameter int H_ACT     = DEF_H_ACT,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int ZONE_COLS = DEF_ZONE_COLS,
    parameter int ZONE_ROWS = DEF_ZONE_ROWS,
    parameter bit VS_POL    = 1'b1
) (
    input  logic                                       I_clk,
    input  logic                                       I_rst,
    input  logic                                       I_vs,
    input  logic                                       I_hs,
    input  logic                                       I_de,
    input  logic [7:0]                                 I_data_r,
    input  logic [7:0]                                 I_data_g,
    input  logic [7:0]                                 I_data_b,
    output logic [BRIGHT_W*ZONE_COLS*ZONE_ROWS-1:0]    O_led_light,
    output logic                                       O_frame_valid,
    output logic                                       O_frame_err
);

    localparam int NZONE = ZONE_COLS * ZONE_ROWS;
    localparam int LW    = BRIGHT_W * NZONE;
    localparam int CMW   = BRIGHT_W * ZONE_COLS;
    localparam int HW    = $clog2(ZONE_COLS + 1);
    localparam int VW    = $clog2(ZONE_ROWS + 1);

    localparam logic [1:0] WAIT_VS = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    logic [1:0]     state;
    bright_t        luma1;
    logic           de1, vs1, vs2, cde2;
    logic           vs_act1, vs_edge, cde1, line_end;
    logic           pix, lend, copy_row, cnt_clr;
    logic [HW-1:0]  h_zone;
    logic           h_last, h_done;
    logic [VW-1:0]  v_zone;
    logic           v_last, v_done;
    logic [CMW-1:0] colmax;
    logic [LW-1:0]  shadow;
    logic           err;
    logic           unused_ok;

    assign unused_ok = ^{I_hs, h_last};

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            luma1 <= '0;
            de1   <= 1'b0;
            vs1   <= !VS_POL;
            vs2   <= !VS_POL;
            cde2  <= 1'b0;
        end else begin
            luma1 <= max3(I_data_r, I_data_g, I_data_b);
            de1   <= I_de;
            vs1   <= I_vs;
            vs2   <= vs1;
            cde2  <= cde1;
        end
    end

    // de during active VS is never counted, so a VS edge mid-line also closes that line
    assign vs_act1  = (vs1 == VS_POL);
    assign vs_edge  = vs_act1 && (vs2 != VS_POL);
    assign cde1     = de1 && !vs_act1;
    assign line_end = cde2 && !cde1;
    assign pix      = (state == ACTIVE) && cde1;
    assign lend     = (state == ACTIVE) && line_end;
    assign copy_row = lend && v_last && !v_done;
    assign cnt_clr  = (state != ACTIVE);

    zone_counter #(.SPAN(H_ACT / ZONE_COLS), .ZONES(ZONE_COLS)) u_hcnt (
        .clk  (I_clk),
        .rst  (I_rst),
        .clr  (cnt_clr || lend),
        .inc  (pix),
        .zone (h_zone),
        .last (h_last),
        .done (h_done)
    );

    zone_counter #(.SPAN(V_ACT / ZONE_ROWS), .ZONES(ZONE_ROWS)) u_vcnt (
        .clk  (I_clk),
        .rst  (I_rst),
        .clr  (cnt_clr),
        .inc  (lend),
        .zone (v_zone),
        .last (v_last),
        .done (v_done)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= WAIT_VS;
        end else begin
            case (state)
                WAIT_VS: if (vs_edge) state <= ACTIVE;
                ACTIVE:  if (vs_edge) state <= COMMIT;
                default: state <= ACTIVE;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst || state != ACTIVE) begin
            err <= 1'b0;
        end else if ((pix && h_done) || (lend && (!h_done || v_done)) || (vs_edge && de1)) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst || state != ACTIVE || copy_row) begin
            colmax <= '0;
        end else if (pix && !h_done && luma1 > colmax[h_zone*BRIGHT_W +: BRIGHT_W]) begin
            colmax[h_zone*BRIGHT_W +: BRIGHT_W] <= luma1;
        end
    end

    // shadow takes the column maxima as they stood before the same-cycle clear above
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            shadow <= '0;
        end else if (copy_row) begin
            for (int c = 0; c < ZONE_COLS; c++) begin
                shadow[zone_idx(int'(v_zone), c, ZONE_COLS)*BRIGHT_W +: BRIGHT_W]
                    <= colmax[c*BRIGHT_W +: BRIGHT_W];
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_led_light   <= '0;
            O_frame_valid <= 1'b0;
            O_frame_err   <= 1'b0;
        end else begin
            O_frame_valid <= 1'b0;
            O_frame_err   <= 1'b0;
            if (state == COMMIT) begin
                if (v_done && !err) begin
                    O_led_light   <= shadow;
                    O_frame_valid <= 1'b1;
                end else begin
                    O_frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
